// File: rtl/asi_mport_arb_if.sv
// Channel-request and memory-port bundle for asi_mport_arb.
// master = the arbiter itself, slave = the requesting channels plus the memory.
interface asi_mport_arb_if #(
  parameter int N_CH   = 4,
  parameter int AXI_DW = 128,
  parameter int AXI_AW = 40,
  parameter int AXI_LW = 8
);
  logic [N_CH-1:0]          req_valid;
  logic [N_CH-1:0]          req_we;
  logic [N_CH*AXI_AW-1:0]   req_addr;
  logic [N_CH*AXI_LW-1:0]   req_len;
  logic [N_CH-1:0]          req_ready;
  logic [N_CH*AXI_DW-1:0]   beat_wdata;
  logic [N_CH*AXI_DW/8-1:0] beat_wstrb;
  logic [N_CH-1:0]          beat_ack;
  logic                     m_we;
  logic                     m_re;
  logic [AXI_AW-1:0]        m_addr;
  logic [AXI_DW-1:0]        m_wdata;
  logic [AXI_DW/8-1:0]      m_wstrb;
  logic [AXI_DW-1:0]        m_rdata;
  logic [N_CH-1:0]          rd_valid;
  logic                     rd_last;
  logic [AXI_DW-1:0]        rd_data;
  logic                     busy;
  logic [$clog2(N_CH)-1:0]  gnt_id;

  modport master (
    input  req_valid, req_we, req_addr, req_len, beat_wdata, beat_wstrb, m_rdata,
    output req_ready, beat_ack, m_we, m_re, m_addr, m_wdata, m_wstrb,
           rd_valid, rd_last, rd_data, busy, gnt_id
  );

  modport slave (
    output req_valid, req_we, req_addr, req_len, beat_wdata, beat_wstrb, m_rdata,
    input  req_ready, beat_ack, m_we, m_re, m_addr, m_wdata, m_wstrb,
           rd_valid, rd_last, rd_data, busy, gnt_id
  );
endinterface

// File: rtl/asi_mport_arb.sv
// Arbitrates N_CH burst requesters onto one memory port, one beat per cycle after a grant cycle.
// Read data returns SLV_WS cycles after each read beat, tagged with owning channel and last flag.
module asi_mport_arb #(
  parameter int N_CH     = 4,
  parameter int AXI_DW   = 128,
  parameter int AXI_AW   = 40,
  parameter int AXI_LW   = 8,
  parameter int SLV_WS   = 2,
  parameter int ARB_MODE = 1
) (
  input  logic            ACLK,
  input  logic            ARESET,
  asi_mport_arb_if.master bus
);
  localparam int IDW   = $clog2(N_CH);
  localparam int BYTES = AXI_DW / 8;
  localparam logic [AXI_AW-1:0] ALIGN_MASK = ~(AXI_AW'(BYTES - 1));

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state, state_nxt;
  logic [IDW-1:0]    last_gnt, gnt_q, win_id, rr_idx;
  logic              win_vld;
  logic [AXI_AW-1:0] addr_q;
  logic [AXI_LW-1:0] len_q, beat_cnt;
  logic              we_q;
  logic              grant, in_burst, last_beat;
  logic              rd_v_in, rd_l_in, rd_v_out, rd_l_out, pipe_busy;
  logic [IDW-1:0]    rd_id_out;

  assign in_burst  = (state == BURST);
  assign last_beat = in_burst && (beat_cnt == len_q);
  // Reset gates the grant so req_ready cannot pulse while ARESET is held.
  assign grant     = (state == IDLE) && win_vld && !ARESET;

  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    rr_idx  = '0;
    if (ARB_MODE == 0) begin
      for (int i = N_CH - 1; i >= 0; i--) begin
        if (bus.req_valid[i]) begin
          win_vld = 1'b1;
          win_id  = IDW'(i);
        end
      end
    end else begin
      // Walk the search order backwards so the first requester after last_gnt wins.
      for (int k = N_CH; k >= 1; k--) begin
        rr_idx = IDW'((int'(last_gnt) + k) % N_CH);
        if (bus.req_valid[rr_idx]) begin
          win_vld = 1'b1;
          win_id  = rr_idx;
        end
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant)     state_nxt = BURST;
      BURST:   if (last_beat) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      last_gnt <= IDW'(N_CH - 1);
      gnt_q    <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
      we_q     <= 1'b0;
    end else if (grant) begin
      last_gnt <= win_id;
      gnt_q    <= win_id;
      addr_q   <= bus.req_addr[win_id*AXI_AW +: AXI_AW];
      len_q    <= bus.req_len[win_id*AXI_LW +: AXI_LW];
      we_q     <= bus.req_we[win_id];
      beat_cnt <= '0;
    end else if (in_burst) begin
      // Only the first beat may be unaligned; later beats step from the aligned base.
      addr_q   <= (addr_q & ALIGN_MASK) + AXI_AW'(BYTES);
      beat_cnt <= beat_cnt + AXI_LW'(1);
    end
  end

  always_comb begin
    bus.req_ready = '0;
    bus.beat_ack  = '0;
    bus.m_we      = 1'b0;
    bus.m_re      = 1'b0;
    bus.m_addr    = '0;
    bus.m_wdata   = '0;
    bus.m_wstrb   = '0;
    if (grant) bus.req_ready[win_id] = 1'b1;
    if (in_burst) begin
      bus.m_we            = we_q;
      bus.m_re            = ~we_q;
      bus.m_addr          = addr_q;
      bus.beat_ack[gnt_q] = 1'b1;
      if (we_q) begin
        bus.m_wdata = bus.beat_wdata[gnt_q*AXI_DW +: AXI_DW];
        bus.m_wstrb = bus.beat_wstrb[gnt_q*(AXI_DW/8) +: (AXI_DW/8)];
      end
    end
  end

  assign rd_v_in = in_burst && !we_q;
  assign rd_l_in = last_beat;

  generate
    if (SLV_WS == 0) begin : g_comb
      assign rd_v_out  = rd_v_in;
      assign rd_l_out  = rd_l_in;
      assign rd_id_out = gnt_q;
      assign pipe_busy = 1'b0;
    end else begin : g_pipe
      logic [SLV_WS-1:0] v_sr, l_sr;
      logic [IDW-1:0]    id_sr [SLV_WS];

      always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
          v_sr <= '0;
          l_sr <= '0;
          for (int k = 0; k < SLV_WS; k++) id_sr[k] <= '0;
        end else begin
          v_sr[0]  <= rd_v_in;
          l_sr[0]  <= rd_l_in;
          id_sr[0] <= gnt_q;
          for (int k = 1; k < SLV_WS; k++) begin
            v_sr[k]  <= v_sr[k-1];
            l_sr[k]  <= l_sr[k-1];
            id_sr[k] <= id_sr[k-1];
          end
        end
      end

      assign rd_v_out  = v_sr[SLV_WS-1];
      assign rd_l_out  = l_sr[SLV_WS-1];
      assign rd_id_out = id_sr[SLV_WS-1];
      assign pipe_busy = |v_sr;
    end
  endgenerate

  always_comb begin
    bus.rd_valid = '0;
    bus.rd_last  = 1'b0;
    bus.rd_data  = '0;
    if (rd_v_out) begin
      bus.rd_valid[rd_id_out] = 1'b1;
      bus.rd_last             = rd_l_out;
      bus.rd_data             = bus.m_rdata;
    end
  end

  assign bus.busy   = in_burst || pipe_busy;
  assign bus.gnt_id = gnt_q;
endmodule

// File: tb/tb_asi_mport_arb.sv
// Drives a round-robin and a fixed-priority arbiter with identical stimulus and checks both
// every cycle against a transaction-level model, plus literal expectations per scenario.
module tb_asi_mport_arb;
  localparam int N = 4, DW = 128, AW = 40, LW = 8, WS = 2;

  logic ACLK = 1'b0, ARESET = 1'b1;
  always #5 ACLK = ~ACLK;

  logic [N-1:0]      req_valid = '0, req_we = '0;
  logic [N*AW-1:0]   req_addr = '0;
  logic [N*LW-1:0]   req_len = '0;
  logic [N*DW-1:0]   beat_wdata = '0;
  logic [N*DW/8-1:0] beat_wstrb = '0;
  logic [DW-1:0]     m_rdata = '0;

  asi_mport_arb_if #(.N_CH(N), .AXI_DW(DW), .AXI_AW(AW), .AXI_LW(LW)) bus0 ();
  asi_mport_arb_if #(.N_CH(N), .AXI_DW(DW), .AXI_AW(AW), .AXI_LW(LW)) bus1 ();

  assign bus0.req_valid = req_valid;  assign bus1.req_valid = req_valid;
  assign bus0.req_we = req_we;        assign bus1.req_we = req_we;
  assign bus0.req_addr = req_addr;    assign bus1.req_addr = req_addr;
  assign bus0.req_len = req_len;      assign bus1.req_len = req_len;
  assign bus0.beat_wdata = beat_wdata; assign bus1.beat_wdata = beat_wdata;
  assign bus0.beat_wstrb = beat_wstrb; assign bus1.beat_wstrb = beat_wstrb;
  assign bus0.m_rdata = m_rdata;      assign bus1.m_rdata = m_rdata;

  asi_mport_arb #(.N_CH(N), .AXI_DW(DW), .AXI_AW(AW), .AXI_LW(LW), .SLV_WS(WS), .ARB_MODE(1))
    dut_rr (.ACLK(ACLK), .ARESET(ARESET), .bus(bus0));
  asi_mport_arb #(.N_CH(N), .AXI_DW(DW), .AXI_AW(AW), .AXI_LW(LW), .SLV_WS(WS), .ARB_MODE(0))
    dut_fx (.ACLK(ACLK), .ARESET(ARESET), .bus(bus1));

  logic [N-1:0]      o_ready[2], o_ack[2], o_rdv[2];
  logic              o_we[2], o_re[2], o_last[2], o_busy[2];
  logic [AW-1:0]     o_addr[2];
  logic [DW-1:0]     o_wdata[2], o_rdata[2];
  logic [DW/8-1:0]   o_wstrb[2];
  logic [1:0]        o_gid[2];
  assign o_ready[0] = bus0.req_ready; assign o_ready[1] = bus1.req_ready;
  assign o_ack[0] = bus0.beat_ack;    assign o_ack[1] = bus1.beat_ack;
  assign o_rdv[0] = bus0.rd_valid;    assign o_rdv[1] = bus1.rd_valid;
  assign o_we[0] = bus0.m_we;         assign o_we[1] = bus1.m_we;
  assign o_re[0] = bus0.m_re;         assign o_re[1] = bus1.m_re;
  assign o_last[0] = bus0.rd_last;    assign o_last[1] = bus1.rd_last;
  assign o_busy[0] = bus0.busy;       assign o_busy[1] = bus1.busy;
  assign o_addr[0] = bus0.m_addr;     assign o_addr[1] = bus1.m_addr;
  assign o_wdata[0] = bus0.m_wdata;   assign o_wdata[1] = bus1.m_wdata;
  assign o_rdata[0] = bus0.rd_data;   assign o_rdata[1] = bus1.rd_data;
  assign o_wstrb[0] = bus0.m_wstrb;   assign o_wstrb[1] = bus1.m_wstrb;
  assign o_gid[0] = bus0.gnt_id;      assign o_gid[1] = bus1.gnt_id;

  typedef struct { logic [AW-1:0] addr; bit we; int id; bit last; } beat_t;
  typedef struct { int due; int id; bit last; } rd_t;

  beat_t mb[2][$];
  rd_t   mr[2][$];
  int    lg[2] = '{N-1, N-1};
  int    cyc = 0, n_chk = 0, n_err = 0;

  int            gnt_log[2][$];
  int            gnt_cyc[2][$];
  logic [AW-1:0] addr_log[$];
  logic [N-1:0]  ack_log[$];
  int            beat_cyc[$], rd_cyc[$];
  bit            rdl_log[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  function automatic int pick(input int mode, input int last, input logic [N-1:0] v);
    if (mode == 0) begin
      for (int i = 0; i < N; i++) if (v[i]) return i;
    end else begin
      for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_cycle(input int d);
    logic [N-1:0]    e_ready, e_ack, e_rdv;
    logic            e_we, e_re, e_last, e_busy;
    logic [AW-1:0]   e_addr, a0;
    logic [DW-1:0]   e_wd;
    logic [DW/8-1:0] e_ws;
    int              w, ln;
    beat_t           b, nb;
    bit              bv;
    string           s;
    s = (d == 0) ? "rr" : "fx";
    if (ARESET) begin
      chk({s, "_rst_ready"}, o_ready[d], 0);
      chk({s, "_rst_ack"}, o_ack[d], 0);
      chk({s, "_rst_we_re"}, {o_we[d], o_re[d]}, 0);
      chk({s, "_rst_addr"}, o_addr[d], 0);
      chk({s, "_rst_wdata"}, o_wdata[d], 0);
      chk({s, "_rst_wstrb"}, o_wstrb[d], 0);
      chk({s, "_rst_rdv"}, {o_rdv[d], o_last[d]}, 0);
      chk({s, "_rst_busy"}, o_busy[d], 0);
      chk({s, "_rst_gid"}, o_gid[d], 0);
      mb[d].delete();
      mr[d].delete();
      lg[d] = N - 1;
      return;
    end
    e_ready = '0; e_ack = '0; e_rdv = '0; e_we = 0; e_re = 0; e_last = 0;
    e_addr = '0; e_wd = '0; e_ws = '0; w = -1;
    b = '{addr: '0, we: 0, id: 0, last: 0};
    bv = (mb[d].size() > 0);
    if (bv) begin
      b = mb[d][0];
      e_we = b.we;
      e_re = !b.we;
      e_addr = b.addr;
      e_ack[b.id] = 1'b1;
      if (b.we) begin
        e_wd = beat_wdata[b.id*DW +: DW];
        e_ws = beat_wstrb[b.id*(DW/8) +: (DW/8)];
      end
      chk({s, "_gnt_id"}, o_gid[d], b.id);
    end else begin
      w = pick(d == 0 ? 1 : 0, lg[d], req_valid);
      if (w >= 0) e_ready[w] = 1'b1;
    end
    if (mr[d].size() > 0 && mr[d][0].due == cyc) begin
      e_rdv[mr[d][0].id] = 1'b1;
      e_last = mr[d][0].last;
      chk({s, "_rd_data"}, o_rdata[d], m_rdata);
    end
    e_busy = bv || (mr[d].size() > 0);
    chk({s, "_req_ready"}, o_ready[d], e_ready);
    chk({s, "_beat_ack"}, o_ack[d], e_ack);
    chk({s, "_m_we_re"}, {o_we[d], o_re[d]}, {e_we, e_re});
    chk({s, "_m_addr"}, o_addr[d], e_addr);
    chk({s, "_m_wdata"}, o_wdata[d], e_wd);
    chk({s, "_m_wstrb"}, o_wstrb[d], e_ws);
    chk({s, "_rd_valid_last"}, {o_rdv[d], o_last[d]}, {e_rdv, e_last});
    chk({s, "_busy"}, o_busy[d], e_busy);

    if (d == 0) begin
      if (o_we[0] || o_re[0]) begin
        addr_log.push_back(o_addr[0]);
        ack_log.push_back(o_ack[0]);
        beat_cyc.push_back(cyc);
      end
      if (|o_rdv[0]) begin
        rd_cyc.push_back(cyc);
        rdl_log.push_back(o_last[0]);
      end
    end
    for (int i = 0; i < N; i++) if (o_ready[d][i]) begin
      gnt_log[d].push_back(i);
      gnt_cyc[d].push_back(cyc);
    end

    if (mr[d].size() > 0 && mr[d][0].due == cyc) void'(mr[d].pop_front());
    if (bv) begin
      if (!b.we) mr[d].push_back('{due: cyc + WS, id: b.id, last: b.last});
      void'(mb[d].pop_front());
    end else if (w >= 0) begin
      ln = int'(req_len[w*LW +: LW]);
      a0 = req_addr[w*AW +: AW];
      for (int k = 0; k <= ln; k++) begin
        nb.addr = (k == 0) ? a0 : ((a0 & {{(AW-4){1'b1}}, 4'h0}) + AW'(k * 16));
        nb.we = req_we[w];
        nb.id = w;
        nb.last = (k == ln);
        mb[d].push_back(nb);
      end
      lg[d] = w;
    end
  endtask

  always @(negedge ACLK) begin
    model_cycle(0);
    model_cycle(1);
    cyc++;
  end

  function automatic int qg(input int d, input int i);
    if (i < gnt_log[d].size()) return gnt_log[d][i];
    return -1;
  endfunction
  function automatic logic [AW-1:0] qa(input int i);
    if (i < addr_log.size()) return addr_log[i];
    return '1;
  endfunction
  function automatic logic [N-1:0] qk(input int i);
    if (i < ack_log.size()) return ack_log[i];
    return 'x;
  endfunction

  task automatic clr_logs();
    addr_log.delete(); ack_log.delete(); beat_cyc.delete();
    rd_cyc.delete(); rdl_log.delete();
    for (int d = 0; d < 2; d++) begin gnt_log[d].delete(); gnt_cyc[d].delete(); end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
    m_rdata = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < N*DW/32; i++) beat_wdata[i*32 +: 32] = $urandom;
    beat_wstrb = {$urandom, $urandom};
  endtask

  task automatic set_req(input int ch, input bit we, input logic [AW-1:0] a, input int len);
    req_we[ch] = we;
    req_addr[ch*AW +: AW] = a;
    req_len[ch*LW +: LW] = LW'(len);
    req_valid[ch] = 1'b1;
  endtask

  task automatic wait_grant(input int ch);
    bit got;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      #1;
      if (o_ready[0][ch]) got = 1;
      else tick();
    end
    chk($sformatf("grant_wait_ch%0d", ch), got, 1);
    tick();
    req_valid[ch] = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      tick();
      if (req_valid == 0 && !o_busy[0] && !o_busy[1]) done = 1;
    end
    chk("drain_timeout", done, 1);
  endtask

  initial begin
    int ok, cnt;
    repeat (3) tick();
    ARESET = 0;
    tick();

    // 4-beat read from ch0, data back WS cycles later, last on 4th return
    clr_logs();
    set_req(0, 0, 40'h100, 3);
    wait_grant(0);
    drain();
    chk("a_gnt0", qg(0, 0), 0);
    chk("a_nbeats", addr_log.size(), 4);
    chk("a_addr0", qa(0), 40'h100);
    chk("a_addr1", qa(1), 40'h110);
    chk("a_addr2", qa(2), 40'h120);
    chk("a_addr3", qa(3), 40'h130);
    chk("a_nrd", rd_cyc.size(), 4);
    for (int i = 0; i < 4 && i < rd_cyc.size() && i < beat_cyc.size(); i++) begin
      chk($sformatf("a_rd_lat%0d", i), rd_cyc[i] - beat_cyc[i], 2);
      chk($sformatf("a_rd_last%0d", i), rdl_log[i], i == 3);
    end

    // unaligned 2-beat write from ch2
    clr_logs();
    set_req(2, 1, 40'h104, 1);
    wait_grant(2);
    drain();
    chk("b_addr0", qa(0), 40'h104);
    chk("b_addr1", qa(1), 40'h110);
    chk("b_ack0", qk(0), 4'b0100);
    chk("b_ack1", qk(1), 4'b0100);

    // address wrap at the top of the 40-bit space
    clr_logs();
    set_req(1, 0, 40'hFF_FFFF_FFF0, 1);
    wait_grant(1);
    drain();
    chk("c_addr0", qa(0), 40'hFF_FFFF_FFF0);
    chk("c_addr1_wrap", qa(1), 40'h0);

    // all channels, len 0, from reset: rr 0,1,2,3,0 two cycles apart; fixed always 0
    ARESET = 1;
    tick();
    ARESET = 0;
    clr_logs();
    for (int ch = 0; ch < N; ch++) set_req(ch, ch[0], 40'h1000 + AW'(ch * 'h40), 0);
    repeat (16) tick();
    req_valid = '0;
    drain();
    chk("d_rr0", qg(0, 0), 0);
    chk("d_rr1", qg(0, 1), 1);
    chk("d_rr2", qg(0, 2), 2);
    chk("d_rr3", qg(0, 3), 3);
    chk("d_rr4", qg(0, 4), 0);
    for (int i = 0; i < 4 && i + 1 < gnt_cyc[0].size(); i++)
      chk($sformatf("d_gap%0d", i), gnt_cyc[0][i+1] - gnt_cyc[0][i], 2);
    ok = 1;
    foreach (gnt_log[1][i]) if (gnt_log[1][i] != 0) ok = 0;
    chk("d_fx_only0", ok, 1);
    chk("d_fx_count", gnt_log[1].size() >= 5, 1);

    // ch1 and ch3 continuous: fixed starves ch3, rr serves it
    clr_logs();
    set_req(1, 1, 40'h2000, 1);
    set_req(3, 0, 40'h3000, 1);
    repeat (20) tick();
    req_valid = '0;
    drain();
    ok = 1;
    foreach (gnt_log[1][i]) if (gnt_log[1][i] != 1) ok = 0;
    chk("e_fx_only1", ok, 1);
    chk("e_fx_count", gnt_log[1].size() >= 5, 1);
    cnt = 0;
    foreach (gnt_log[0][i]) if (gnt_log[0][i] == 3) cnt++;
    chk("e_rr_ch3_served", cnt >= 2, 1);

    // other channels toggling during a long write must not disturb it
    clr_logs();
    set_req(3, 1, 40'h2008, 5);
    wait_grant(3);
    for (int i = 0; i < 4; i++) begin
      req_addr[0 +: AW] = AW'($urandom);
      req_len[0 +: LW] = LW'(i);
      req_valid[2:0] = 3'($urandom);
      tick();
    end
    req_valid = '0;
    drain();
    chk("f_nbeats", addr_log.size(), 6);
    chk("f_addr5", qa(5), 40'h2050);

    // reset during beat 2 of an 8-beat read
    clr_logs();
    set_req(0, 0, 40'h300, 7);
    wait_grant(0);
    tick();
    tick();
    ARESET = 1;
    #1;
    chk("g_re_now", o_re[0], 0);
    chk("g_addr_now", o_addr[0], 0);
    chk("g_busy_now", o_busy[0], 0);
    tick();
    ARESET = 0;
    repeat (6) tick();
    chk("g_no_stale_rd", rd_cyc.size(), 0);
    clr_logs();
    for (int ch = 0; ch < N; ch++) set_req(ch, 1, 40'h4000, 0);
    wait_grant(0);
    req_valid = '0;
    drain();
    chk("g_rr_first_ch0", qg(0, 0), 0);
    chk("g_fx_first_ch0", qg(1, 0), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/asi_mport_arb.md
ASI_MPORT_ARB -- requirements
Module: asi_mport_arb

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of requesting channels (2..16).
REQ-002 SHALL have parameter AXI_DW, default 128, memory data width in bits.
REQ-003 SHALL have parameter AXI_AW, default 40, address width.
REQ-004 SHALL have parameter AXI_LW, default 8, burst-length field width (beats-1).
REQ-005 SHALL have parameter SLV_WS, default 2, read wait states (0..8) from m_re to m_rdata valid.
REQ-006 SHALL have parameter ARB_MODE, default 1: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-007 SHALL have one clock and an asynchronous active-high reset: ACLK input 1, rising-edge clock; ARESET input 1, asynchronous active-high reset.
REQ-008 req_valid input N_CH: per-channel burst request.
REQ-009 req_we input N_CH: 1 = write burst, 0 = read burst.
REQ-010 req_addr input N_CH*AXI_AW: start byte address; channel i at slice i.
REQ-011 req_len input N_CH*AXI_LW: beats-1 per channel.
REQ-012 req_ready output N_CH: one-cycle grant pulse, request accepted.
REQ-013 beat_wdata input N_CH*AXI_DW, beat_wstrb input N_CH*AXI_DW/8: per-channel write beat.
REQ-014 beat_ack output N_CH: high in each cycle a beat of that channel is issued.
REQ-015 m_we, m_re output 1; m_addr output AXI_AW; m_wdata output AXI_DW; m_wstrb output AXI_DW/8; m_rdata input AXI_DW.
REQ-016 rd_valid output N_CH (one-hot), rd_last output 1, rd_data output AXI_DW: read return.
REQ-017 busy output 1; gnt_id output clog2(N_CH): current owner.

Function
REQ-018 FSM states SHALL be IDLE and BURST; reset state IDLE.
REQ-019 IDLE: any req_valid -> select winner per ARB_MODE, latch addr/len/we/id, pulse req_ready[winner] that cycle, go BURST next cycle.
REQ-020 Round-robin: search starts at last_gnt+1 modulo N_CH; last_gnt updated on each grant; reset value N_CH-1 (channel 0 wins first).
REQ-021 BURST: exactly one beat per cycle, len+1 cycles; m_we=req_we, m_re=~req_we; beat_ack[gnt_id]=1 each beat.
REQ-022 Beat 0 address = latched req_addr; beat k>0 address = (req_addr aligned down to AXI_DW/8) + k*AXI_DW/8, modulo 2^AXI_AW.
REQ-023 Write beats: m_wdata/m_wstrb = beat_wdata/beat_wstrb slice of gnt_id, combinational same cycle.
REQ-024 After last beat FSM SHALL return to IDLE; minimum one IDLE cycle between bursts.
REQ-025 req_valid changes of any channel during BURST SHALL not affect the active burst.
REQ-026 Read return: pipeline of SLV_WS stages carrying valid, id, last; rd_valid[id]=1 exactly SLV_WS cycles after m_re; rd_data = m_rdata that cycle; rd_last on final beat; SLV_WS=0 combinational.
REQ-027 Outside BURST: m_we=m_re=0, m_addr=0, m_wdata=0, m_wstrb=0, beat_ack=0; busy=1 only in BURST or while read pipeline holds valid.
REQ-028 len=0 SHALL produce single-beat burst with rd_last (read) on that beat.
REQ-029 Simultaneous requests all channels in fixed mode: lowest index always wins (starvation permitted).

Reset
REQ-030 ARESET high SHALL immediately force IDLE, all outputs 0, gnt_id 0, read pipeline flushed, last_gnt=N_CH-1, even mid-burst.
REQ-031 Bursts in progress at reset SHALL be abandoned; no rd_valid after reset release for pre-reset reads.

Verification
REQ-032 Ch0 read addr 0x100 len 3, SLV_WS=2 -> m_re 4 cycles addr 0x100,0x110,0x120,0x130; rd_valid[0] 2 cycles later each, rd_last on 4th.
REQ-033 Ch2 write addr 0x104 len 1 -> m_addr 0x104 then 0x110; beat_ack[2] both cycles; m_wstrb equals beat_wstrb slice 2.
REQ-034 ARB_MODE=1, all 4 channels request continuously, len 0 -> grant order 0,1,2,3,0 with one idle cycle between.
REQ-035 ARB_MODE=0, ch1 and ch3 request continuously -> ch1 granted every time, ch3 never.
REQ-036 ARESET pulse during beat 2 of 8-beat read -> outputs 0 same cycle, no rd_valid after release, next grant goes to ch0.
REQ-037 Addr 0xFF_FFFF_FFF0 len 1 (AXI_AW=40) -> second beat m_addr 0x0 (wrap).
